// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding,
// flag bit positions and the digit-counter width helper.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, the building block of the per-digit ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB
// first, carry held in a flop between digits, valid/ready on both sides.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_add_sub: WIDTH must be >= 2 and an exact multiple of DIGIT");
  end

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   carry_q, carry_d;
  logic [WIDTH-1:0]       op_a_q, op_a_d;
  logic [WIDTH-1:0]       op_b_q, op_b_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;
  logic                   out_valid_q, out_valid_d;

  logic [DIGIT-1:0]       dig_a, dig_b, dig_s;
  logic [DIGIT:0]         chain_c;

  assign dig_a      = op_a_q[cnt_q*DIGIT +: DIGIT];
  assign dig_b      = op_b_q[cnt_q*DIGIT +: DIGIT];
  assign chain_c[0] = carry_q;

  // Ripple chain; the carry into the last cell doubles as the carry into the MSB.
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fa_cell u_fa (
      .a  (dig_a[i]),
      .b  (dig_b[i]),
      .ci (chain_c[i]),
      .s  (dig_s[i]),
      .co (chain_c[i+1])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[cnt_q*DIGIT +: DIGIT] = dig_s;
        carry_d = chain_c[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          flags_d[FLAG_C] = chain_c[DIGIT];
          flags_d[FLAG_V] = chain_c[DIGIT] ^ chain_c[DIGIT-1];
          flags_d[FLAG_Z] = (result_d == '0);
          flags_d[FLAG_N] = result_d[WIDTH-1];
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_n    = flags_q[FLAG_N];

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: four configurations (8/1, 8/4, 8/8, 4/2)
// sharing one clock and reset; flags are compared packed as {n,z,v,c}.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid [4];
  logic       out_ready[4];
  logic       sub      [4];
  logic [7:0] a        [3];
  logic [7:0] b        [3];
  logic [3:0] a4, b4;
  logic       in_ready [4];
  logic       out_valid[4];
  logic [7:0] res      [3];
  logic [3:0] res4;
  logic       fc[4], fv[4], fz[4], fn[4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .sub(sub[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(res[0]), .flag_c(fc[0]), .flag_v(fv[0]), .flag_z(fz[0]), .flag_n(fn[0]));

  serial_add_sub #(.WIDTH(8), .DIGIT(4)) u8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .sub(sub[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(res[1]), .flag_c(fc[1]), .flag_v(fv[1]), .flag_z(fz[1]), .flag_n(fn[1]));

  serial_add_sub #(.WIDTH(8), .DIGIT(8)) u8d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .sub(sub[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .result(res[2]), .flag_c(fc[2]), .flag_v(fv[2]), .flag_z(fz[2]), .flag_n(fn[2]));

  serial_add_sub #(.WIDTH(4), .DIGIT(2)) u4d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a(a4), .b(b4), .sub(sub[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .result(res4), .flag_c(fc[3]), .flag_v(fv[3]), .flag_z(fz[3]), .flag_n(fn[3]));

  function automatic int ndig(input int inst);
    case (inst)
      0:       return 8;
      1:       return 2;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] get_res(input int inst);
    return (inst == 3) ? {4'h0, res4} : res[inst];
  endfunction

  function automatic logic [3:0] get_flags(input int inst);
    return {fn[inst], fz[inst], fv[inst], fc[inst]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int inst, input logic [7:0] av, input logic [7:0] bv,
                               input logic sv);
    @(negedge clk);
    if (inst == 3) begin
      a4 = av[3:0];
      b4 = bv[3:0];
    end else begin
      a[inst] = av;
      b[inst] = bv;
    end
    sub[inst]      = sv;
    in_valid[inst] = 1'b1;
    checkOutput("in_ready_idle", in_ready[inst], 1'b1);
    @(posedge clk);
    #1;
    in_valid[inst] = 1'b0;
  endtask

  task automatic waitResult(input int inst, output int lat);
    lat = 0;
    while (!out_valid[inst] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult(input int inst);
    @(negedge clk);
    out_ready[inst] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("out_valid_after_hs", out_valid[inst], 1'b0);
    checkOutput("in_ready_after_hs", in_ready[inst], 1'b1);
    out_ready[inst] = 1'b0;
  endtask

  task automatic runOp(input int inst, input string tag, input logic [7:0] av,
                       input logic [7:0] bv, input logic sv, input logic [7:0] exp_res,
                       input logic [3:0] exp_flags, input int stall);
    int lat;
    applyStimulus(inst, av, bv, sv);
    waitResult(inst, lat);
    checkOutput({tag, "_latency"}, lat, ndig(inst));
    checkOutput({tag, "_result"}, get_res(inst), exp_res);
    checkOutput({tag, "_flags"}, get_flags(inst), exp_flags);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, out_valid[inst], 1'b1);
      checkOutput({tag, "_hold_result"}, get_res(inst), exp_res);
      checkOutput({tag, "_hold_flags"}, get_flags(inst), exp_flags);
    end
    releaseResult(inst);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [4:0] full;
    logic [3:0] mres, bx;
    logic       mv;

    rst_n = 1'b0;
    a4 = '0;
    b4 = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      sub[i]       = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      b[i] = '0;
    end

    // Reset state, inputs asserted to show they are ignored
    #12;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid[0], 1'b0);
    checkOutput("rst_in_ready", in_ready[0], 1'b1);
    checkOutput("rst_result", res[0], 8'h00);
    checkOutput("rst_flags", get_flags(0), 4'h0);
    checkOutput("rst_flags_d4", get_flags(1), 4'h0);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Basic add/sub on the bit-serial configuration
    runOp(0, "add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1010, 0);
    runOp(0, "sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 4'b0101, 0);
    runOp(0, "sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 4'b1000, 0);
    runOp(0, "sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011, 0);

    // Backpressure with an ignored in_valid pulse during DONE
    applyStimulus(0, 8'h12, 8'h34, 1'b0);
    waitResult(0, lat);
    checkOutput("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a[0] = 8'hAA;
        b[0] = 8'h55;
        sub[0] = 1'b1;
        in_valid[0] = 1'b1;
      end else begin
        in_valid[0] = 1'b0;
      end
      checkOutput("bp_in_ready", in_ready[0], 1'b0);
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", out_valid[0], 1'b1);
      checkOutput("bp_result", res[0], 8'h46);
      checkOutput("bp_flags", get_flags(0), 4'b0000);
    end
    in_valid[0] = 1'b0;
    releaseResult(0);
    runOp(0, "after_bp", 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, 0);

    // Reset during RUN abandons the operation and clears the carry
    applyStimulus(0, 8'hFF, 8'h01, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstrun_out_valid", out_valid[0], 1'b0);
    checkOutput("rstrun_in_ready", in_ready[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    runOp(0, "post_rst_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 4'b0000, 0);

    // Reset during DONE drops out_valid without waiting for a clock
    applyStimulus(1, 8'h01, 8'h02, 1'b0);
    waitResult(1, lat);
    checkOutput("rstdone_pre_valid", out_valid[1], 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstdone_out_valid", out_valid[1], 1'b0);
    checkOutput("rstdone_result", res[1], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Wider digits
    runOp(1, "d4_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0101, 2);
    runOp(1, "d4_sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011, 0);
    runOp(2, "d8_40_40", 8'h40, 8'h40, 1'b0, 8'h80, 4'b1010, 1);
    runOp(2, "d8_sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 4'b0101, 0);

    // Exhaustive 4-bit, 2 bits per digit, random stalls
    for (int sv = 0; sv < 2; sv++) begin
      for (int av = 0; av < 16; av++) begin
        for (int bv = 0; bv < 16; bv++) begin
          bx   = (sv != 0) ? ~bv[3:0] : bv[3:0];
          full = {1'b0, av[3:0]} + {1'b0, bx} + {4'b0, sv[0]};
          mres = full[3:0];
          if (sv != 0)
            mv = (av[3] != bv[3]) && (mres[3] != av[3]);
          else
            mv = (av[3] == bv[3]) && (mres[3] != av[3]);
          runOp(3, "w4d2", {4'h0, av[3:0]}, {4'h0, bv[3:0]}, sv[0], {4'h0, mres},
                {mres[3], (mres == 4'h0), mv, full[4]}, $urandom_range(0, 2));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
